axi_led_slave: RTL and testbench

AXI4-Lite responder that terminates the LED write traffic issued by the dance/pattern masters on the Nexys-A7. Owns a 16-bit LED register and, optionally, a PWM brightness register, and drives the board's 16 LEDs from a registered output stage. Sits behind the AXI interconnect at the LED base address. The interconnect decodes the upper address bits.

---
 rtl/axi_led_pkg.sv | 18 +
 rtl/led_pwm.sv | 30 +++
 rtl/axi_led_slave.sv | 165 ++++++++++++++++
 tb/tb_axi_led_slave.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_led_pkg.sv
// rtl/axi_led_pkg.sv - register indices, response codes and lane-merge helper for axi_led_slave
package axi_led_pkg;

  localparam logic [1:0] LED_IDX     = 2'd0;
  localparam logic [1:0] BRIGHT_IDX  = 2'd1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-lane merge for the 16-bit register window; only lanes 0 and 1 exist.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic [1:0]  strb);
    merge_lanes = {strb[1] ? new_val[15:8] : old_val[15:8],
                   strb[0] ? new_val[7:0]  : old_val[7:0]};
  endfunction

endpackage

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - free-running PWM counter gating the LED register onto a registered output
module led_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [15:0]         led_reg,
  input  logic [PWM_BITS-1:0] bright,
  output logic [15:0]         led
);

  logic [PWM_BITS-1:0] cnt;
  logic                lit;

  // All-ones brightness means fully on, so the wrap cycle never blanks the LEDs.
  always_comb lit = (cnt < bright) || (&bright);

  // Counter wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else         cnt <= cnt + PWM_BITS'(1);
  end

  // Registered LED drive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) led <= '0;
    else         led <= lit ? led_reg : 16'h0000;
  end

endmodule

// File: rtl/axi_led_slave.sv
// rtl/axi_led_slave.sv - AXI4-Lite LED register responder; LED_PWM_EN adds BRIGHT register and PWM
module axi_led_slave
  import axi_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [15:0] led
);

  logic [15:0] led_reg;
  logic        aw_held, w_held;
  logic [1:0]  aw_idx_q;
  logic [15:0] wdata_q;
  logic [1:0]  wstrb_q;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
  logic [1:0]  wr_idx, wr_strb, ar_idx;
  logic [15:0] wr_data;
  logic        wr_ok, rd_ok;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:4],
                         S_AXI_ARADDR[1:0], S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

  assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign b_hs  = S_AXI_BVALID && S_AXI_BREADY;
  assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;

  // Held flags stay set while BVALID is up, so guard against re-committing.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !S_AXI_BVALID;
  assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_held ? wdata_q : S_AXI_WDATA[15:0];
  assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB[1:0];
  assign ar_idx  = S_AXI_ARADDR[3:2];

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] bright;
`endif

  // Decode whether the write target is a mapped register.
  always_comb begin
    wr_ok = (wr_idx == LED_IDX);
`ifdef LED_PWM_EN
    if (wr_idx == BRIGHT_IDX) wr_ok = 1'b1;
`endif
  end

  // Read mux; unmapped indices return zero data.
  always_comb begin
    rd_ok   = 1'b0;
    rd_data = 32'h0;
    if (ar_idx == LED_IDX) begin
      rd_ok   = 1'b1;
      rd_data = {16'h0000, led_reg};
    end
`ifdef LED_PWM_EN
    if (ar_idx == BRIGHT_IDX) begin
      rd_ok   = 1'b1;
      rd_data = 32'(bright);
    end
`endif
  end

  // Write channel capture, commit and response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx_q     <= 2'b00;
      wdata_q      <= 16'h0000;
      wstrb_q      <= 2'b00;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= S_AXI_WDATA[15:0];
        wstrb_q <= S_AXI_WSTRB[1:0];
      end
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        S_AXI_BVALID <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  // LED register update on a committed write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              led_reg <= 16'h0000;
    else if (commit && (wr_idx == LED_IDX))   led_reg <= merge_lanes(led_reg, wr_data, wr_strb);
  end

  // Read channel: latch data and response on the AR handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= 32'h0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_data;
      S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

`ifdef LED_PWM_EN
  // Brightness register, reset to fully on.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      bright <= '1;
    else if (commit && (wr_idx == BRIGHT_IDX))
      bright <= PWM_BITS'(merge_lanes(16'(bright), wr_data, wr_strb));
  end

  led_pwm #(.PWM_BITS(PWM_BITS)) u_led_pwm (
    .clk     (clk),
    .resetn  (resetn),
    .led_reg (led_reg),
    .bright  (bright),
    .led     (led)
  );
`else
  // Plain registered LED drive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) led <= 16'h0000;
    else         led <= led_reg;
  end
`endif

endmodule

// File: tb/tb_axi_led_slave.sv
// tb/tb_axi_led_slave.sv - scoreboard bench for axi_led_slave (default build and LED_PWM_EN)
module tb_axi_led_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [15:0] m_led    = 16'h0000;
  logic [7:0]  m_bright = 8'hff;

  always #5 clk = ~clk;

  axi_led_slave dut (
    .clk           (clk),
    .resetn        (resetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .led           (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    if (addr[3:2] == 2'd0) begin
      if (strb[0]) m_led[7:0]  = data[7:0];
      if (strb[1]) m_led[15:8] = data[15:8];
      return 2'b00;
    end
`ifdef LED_PWM_EN
    if (addr[3:2] == 2'd1) begin
      if (strb[0]) m_bright = data[7:0];
      return 2'b00;
    end
`endif
    return 2'b10;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    if (addr[3:2] == 2'd0) return {2'b00, 16'h0000, m_led};
`ifdef LED_PWM_EN
    if (addr[3:2] == 2'd1) return {2'b00, 24'h0, m_bright};
`endif
    return {2'b10, 32'h0};
  endfunction

  task automatic collect_b(input string tag);
    logic [1:0] e;
    int k = 0;
    while (!bvalid && k < 20) begin step(); k++; end
    e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'b11;
    chk({tag, " bvalid"}, bvalid, 1);
    chk({tag, " bresp"}, bresp, e);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk({tag, " bvalid drop"}, bvalid, 0);
  endtask

  task automatic collect_r(input string tag);
    logic [33:0] e;
    int k = 0;
    while (!rvalid && k < 20) begin step(); k++; end
    e = (exp_r.size() > 0) ? exp_r.pop_front() : 34'h3_ffff_ffff;
    chk({tag, " rvalid"}, rvalid, 1);
    chk({tag, " rresp"}, rresp, e[33:32]);
    chk({tag, " rdata"}, rdata, e[31:0]);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk({tag, " rvalid drop"}, rvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input string tag);
    logic [15:0] old_led;
    logic        led_stable;
    old_led    = m_led;
    led_stable = (m_bright == 8'hff);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    chk({tag, " awready"}, awready, 1);
    chk({tag, " wready"}, wready, 1);
    exp_b.push_back(model_write(addr, data, strb));
    led_stable = led_stable && (m_bright == 8'hff);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, " bvalid at N+1"}, bvalid, 1);
    if (led_stable) chk({tag, " led at N+1"}, led, old_led);
    step();
    if (led_stable) chk({tag, " led at N+2"}, led, m_led);
    collect_b(tag);
  endtask

  task automatic do_read(input logic [31:0] addr, input string tag);
    araddr = addr; arvalid = 1'b1;
    chk({tag, " arready"}, arready, 1);
    exp_r.push_back(model_read(addr));
    step();
    arvalid = 1'b0;
    chk({tag, " rvalid at N+1"}, rvalid, 1);
    collect_r(tag);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " awready"}, awready, 1);
    chk({tag, " wready"}, wready, 1);
    chk({tag, " arready"}, arready, 1);
    chk({tag, " bvalid"}, bvalid, 0);
    chk({tag, " rvalid"}, rvalid, 0);
    chk({tag, " bresp"}, bresp, 0);
    chk({tag, " rresp"}, rresp, 0);
    chk({tag, " rdata"}, rdata, 0);
    chk({tag, " led"}, led, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] old_rd;
    int          on_cnt;

    #3 resetn = 1'b0;
    #1 chk_reset_state("reset");
    step(); step();
    #2 resetn = 1'b1;
    step();
    chk_reset_state("post-reset");

    // Same-cycle AW/W write; led follows two cycles after the handshake.
    do_write(32'h0, 32'h0000_e007, 4'hf, "wr e007");
    do_read(32'h0, "rd e007");

    // W arrives three cycles before AW.
    awaddr = 32'h0; wdata = 32'h0000_1234; wstrb = 4'hf; wvalid = 1'b1;
    chk("split wready", wready, 1);
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("split wready held", wready, 0);
      chk("split no bvalid", bvalid, 0);
      step();
    end
    chk("split wready held", wready, 0);
    awvalid = 1'b1;
    chk("split awready", awready, 1);
    exp_b.push_back(model_write(32'h0, 32'h0000_1234, 4'hf));
    step();
    awvalid = 1'b0;
    chk("split bvalid after AW", bvalid, 1);
    collect_b("split");
    do_read(32'h0, "rd 1234");

    // Lane 0 only over a cleared register.
    do_write(32'h0, 32'h0, 4'hf, "clear");
    do_write(32'h0, 32'h0000_ffff, 4'h1, "strb1");
    do_read(32'h0, "rd 00ff");

    // Unmapped and conditionally mapped indices.
    do_write(32'hc, 32'h0000_abcd, 4'hf, "wr 0xc");
    do_read(32'hc, "rd 0xc");
    do_read(32'h8, "rd 0x8");
    do_read(32'h4, "rd 0x4");
    do_read(32'h0, "rd after slverr");

    // Stalled responses with a same-cycle read of the register being written.
    old_rd = model_read(32'h0);
    awaddr = 32'h0; wdata = 32'h0000_5a5a; wstrb = 4'h3; araddr = 32'h0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    exp_b.push_back(model_write(32'h0, 32'h0000_5a5a, 4'h3));
    exp_r.push_back(old_rd);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall bvalid", bvalid, 1);
      chk("stall rvalid", rvalid, 1);
      chk("stall bresp", bresp, 0);
      chk("stall rdata old", rdata, old_rd[31:0]);
      chk("stall awready", awready, 0);
      chk("stall wready", wready, 0);
      chk("stall arready", arready, 0);
      step();
    end
    collect_b("stall");
    collect_r("stall");
    chk("stall led", led, m_led);

    // Reset while AW is held and W is still pending.
    awaddr = 32'h0; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("mid aw held", awready, 0);
    chk("mid w pending", wready, 1);
    #2 resetn = 1'b0;
    #1 chk_reset_state("async reset");
    exp_b.delete();
    exp_r.delete();
    m_led = 16'h0000;
    m_bright = 8'hff;
    #2 resetn = 1'b1;
    step();
    do_read(32'h0, "rd after reset");
    do_write(32'h0, 32'h0000_00c3, 4'hf, "wr after reset");
    do_read(32'h0, "rd c3");

`ifdef LED_PWM_EN
    do_read(32'h4, "bright reset");
    do_write(32'h0, 32'h0000_ffff, 4'hf, "pwm led");
    do_write(32'h4, 32'h0000_0040, 4'hf, "pwm bright");
    do_read(32'h4, "rd bright");
    step();
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (led == 16'hffff) on_cnt++;
      step();
    end
    chk("pwm duty 64/256", on_cnt, 64);
    do_write(32'h4, 32'h0, 4'hf, "pwm off");
    step();
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (led != 16'h0000) on_cnt++;
      step();
    end
    chk("pwm bright0 off", on_cnt, 0);
`else
    on_cnt = 0;
    old_rd = 34'h0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
